// File: rtl/packer_pkg.sv
// Shared types and width helpers for the FIFO word packer.
package packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Sliced down to RATIO lanes by the user.
    localparam logic [63:0] KEEP_ALL = '1;

    function automatic int unsigned lane_cnt_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned idle_cnt_w(input int unsigned cycles);
        return (cycles >= 1) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle counter for a partially filled word; pulses o_flush once the word has
// sat untouched for TIMEOUT_CYCLES cycles. Used only with PACKER_TIMEOUT_EN.
module packer_idle_timer
    import packer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_accept,
    output logic o_flush
);

    localparam int unsigned IW = idle_cnt_w(TIMEOUT_CYCLES);

    logic [IW-1:0] r_idle_cnt;

    // An accept in the timeout cycle wins: the beat joins the word instead.
    assign o_flush = i_active & ~i_accept & (r_idle_cnt == IW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (i_accept || o_flush) begin
            r_idle_cnt <= '0;
        end else if (i_active) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs RATIO narrow beats into one wide registered word (lane 0 = first beat).
// Define PACKER_TIMEOUT_EN to flush partial words after TIMEOUT_CYCLES idle cycles.
module fifo_word_packer
    import packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RATIO          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid_i,
    input  logic [DATA_WIDTH-1:0]         in_data_i,
    output logic                          in_grant_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH*RATIO-1:0]   out_data_o,
    output logic [RATIO-1:0]              out_keep_o,
    input  logic                          out_grant_i
);

    localparam int unsigned LW = lane_cnt_w(RATIO);
    localparam int unsigned OW = DATA_WIDTH * RATIO;

    state_e                  r_state;
    logic [LW-1:0]           r_lane_cnt;
    logic [DATA_WIDTH-1:0]   r_acc [RATIO];
    logic                    r_out_valid;
    logic [OW-1:0]           r_out_data;
    logic [RATIO-1:0]        r_out_keep;

    logic                    w_accept;
    logic                    w_out_free;
    logic                    w_complete;
    logic                    w_flush;
    logic                    w_new_word;
    logic [OW-1:0]           w_word;
    logic [RATIO-1:0]        w_keep_all;
    logic [RATIO-1:0]        w_word_keep;
    logic [RATIO-1:0]        w_hold_keep;

    assign w_keep_all = KEEP_ALL[RATIO-1:0];
    assign w_accept   = in_valid_i & (r_state == FILL);
    assign w_out_free = ~r_out_valid | out_grant_i;
    assign w_complete = w_accept & (r_lane_cnt == LW'(RATIO - 1));
    assign w_new_word = w_complete | w_flush;

`ifdef PACKER_TIMEOUT_EN
    logic [RATIO-1:0] w_part_keep;
    logic [RATIO-1:0] r_hold_keep;

    packer_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_active ((r_state == FILL) && (r_lane_cnt != '0)),
        .i_accept (w_accept),
        .o_flush  (w_flush)
    );

    always_comb begin
        w_part_keep = '0;
        for (int l = 0; l < int'(RATIO); l++) begin
            w_part_keep[l] = (LW'(l) < r_lane_cnt);
        end
    end

    assign w_word_keep = w_complete ? w_keep_all : w_part_keep;
    assign w_hold_keep = r_hold_keep;

    // A flushed word stalled into HOLD must remember its partial mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_keep <= '0;
        end else if ((r_state == FILL) && w_new_word && !w_out_free) begin
            r_hold_keep <= w_word_keep;
        end
    end
`else
    assign w_flush     = 1'b0;
    assign w_word_keep = w_keep_all;
    assign w_hold_keep = w_keep_all;
`endif

    // Accumulator contents with this cycle's beat merged into its lane.
    always_comb begin
        w_word = '0;
        for (int l = 0; l < int'(RATIO); l++) begin
            w_word[l*DATA_WIDTH +: DATA_WIDTH] =
                (w_accept && (r_lane_cnt == LW'(l))) ? in_data_i : r_acc[l];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FILL;
            r_lane_cnt  <= '0;
            for (int l = 0; l < int'(RATIO); l++) begin
                r_acc[l] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_new_word) begin
                        if (w_out_free) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_word;
                            r_out_keep  <= w_word_keep;
                            r_lane_cnt  <= '0;
                            for (int l = 0; l < int'(RATIO); l++) begin
                                r_acc[l] <= '0;
                            end
                        end else begin
                            r_state <= HOLD;
                            for (int l = 0; l < int'(RATIO); l++) begin
                                r_acc[l] <= w_word[l*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end else begin
                        if (w_accept) begin
                            r_acc[r_lane_cnt] <= in_data_i;
                            r_lane_cnt        <= r_lane_cnt + LW'(1);
                        end
                        if (w_out_free) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (w_out_free) begin
                        r_state     <= FILL;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_word;
                        r_out_keep  <= w_hold_keep;
                        r_lane_cnt  <= '0;
                        for (int l = 0; l < int'(RATIO); l++) begin
                            r_acc[l] <= '0;
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_grant_o  = (r_state == FILL);
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_keep_o  = r_out_keep;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a word scoreboard; honours PACKER_TIMEOUT_EN.
module tb_fifo_word_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_grant;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_grant = 1'b0;

    int   total = 0;
    int   bad = 0;
    int   n_xfer = 0;
    exp_t q[$];
    logic [7:0] m_lane [4];
    int   m_cnt = 0;

    fifo_word_packer #(
        .DATA_WIDTH     (8),
        .RATIO          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_grant_o  (in_grant),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_grant_i (out_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d);
        m_lane[m_cnt] = d;
        m_cnt++;
        if (m_cnt == 4) begin
            q.push_back('{data: {m_lane[3], m_lane[2], m_lane[1], m_lane[0]}, keep: 4'hF});
            m_cnt = 0;
        end
    endtask

    // Returns at posedge+1 with the beat accepted on that edge.
    task automatic send_beat(input logic [7:0] d, output bit stalled);
        int n = 0;
        stalled = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_grant && n < 50) begin
            stalled = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("grant_wait_bound", {63'd0, in_grant}, 64'd1);
        if (in_grant) model_accept(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: a transfer happens on the next edge when valid & grant here.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_grant) begin
            n_xfer++;
            chk("word_expected", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("word_data", 64'(out_data), 64'(e.data));
                chk("word_keep", 64'(out_keep), 64'(e.keep));
            end
        end
    end

    initial begin
        bit st;
        bit st_any;
        int x0;

        // 1. reset with in_valid high
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_grant", {63'd0, in_grant}, 64'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // 2. one word, downstream always ready
        out_grant = 1'b1;
        send_beat(8'h11, st);
        send_beat(8'h22, st);
        send_beat(8'h33, st);
        send_beat(8'h44, st);
        chk("t2_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_data", 64'(out_data), 64'h44332211);
        chk("t2_keep", 64'(out_keep), 64'hF);
        wait_drain("t2_drain", 20);

        // 3. stalled output: second word goes to HOLD, both delivered
        out_grant = 1'b0;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), st);
        @(negedge clk);
        chk("t3_hold_grant", {63'd0, in_grant}, 64'd0);
        chk("t3_held_data", 64'(out_data), 64'h04030201);
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        wait_drain("t3_drain", 20);
        chk("t3_grant_back", {63'd0, in_grant}, 64'd1);

        // 4. continuous stream, no HOLD bubble
        x0 = n_xfer;
        st_any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_beat(8'(8'hA0 + i), st);
            st_any |= st;
        end
        chk("t4_no_stall", {63'd0, st_any}, 64'd0);
        wait_drain("t4_drain", 20);
        chk("t4_words", 64'(n_xfer - x0), 64'd3);

        // 5. partial word
        x0 = n_xfer;
        send_beat(8'hAA, st);
        send_beat(8'hBB, st);
`ifdef PACKER_TIMEOUT_EN
        q.push_back('{data: 32'h0000BBAA, keep: 4'h3});
        m_cnt = 0;
        wait_drain("t5_flush", 40);
        chk("t5_words", 64'(n_xfer - x0), 64'd1);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("t5_no_flush_words", 64'(n_xfer - x0), 64'd0);
        chk("t5_no_flush_valid", {63'd0, out_valid}, 64'd0);
`endif

        // 6. reset with a held word and two lanes filled
        out_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'(8'hC0 + i), st);
        while (m_cnt != 2) send_beat(8'hD0, st);
        chk("t6_held_before", {63'd0, out_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_grant", {63'd0, in_grant}, 64'd1);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        x0 = n_xfer;
        send_beat(8'hE1, st);
        send_beat(8'hE2, st);
        send_beat(8'hE3, st);
        send_beat(8'hE4, st);
        chk("t6_new_data", 64'(out_data), 64'hE4E3E2E1);
        wait_drain("t6_drain", 20);
        chk("t6_words", 64'(n_xfer - x0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
